sid_voice_bank: RTL and testbench

- Time-multiplexed bank of NUM_VOICES SID-style oscillator/waveform voices sharing one datapath; processes one voice per clock after each ce_1m tick.
- Parametrised successor of the single 8580 voice: configurable accumulator width and voice count.
- Adds circular sync/ring-mod chaining between any voice count, tick pending/overrun handling, and a streamed per-voice output.
- Sits between the SID register decoder and the mixer/filter.

---
 rtl/sid_voice_bank.sv | 272 +++++++++++++++++++++++++++
 tb/tb_sid_voice_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_voice_bank.sv
// sid_voice_bank
//   Time-multiplexed bank of NUM_VOICES SID-style oscillator/waveform voices.
//   One shared datapath processes one voice per clock after each ce_1m tick.
//   Voice v takes its sync/ring source from voice (v-1) mod NUM_VOICES.
//   Sync and ring use MSB snapshots taken at the end of the previous sweep.
//   That way, results do not depend on the order in which voices are processed.
//
// Optional feature macro: SID_VOICE_BANK_DCA_EN
//   defined   : out_wave = (wave * level) >> 8, using the per-voice level register
//   undefined : the level register is writable but out_wave is the raw waveform
//
// Ports
//   clock      system clock
//   reset      asynchronous active-low reset
//   ce_1m      sample tick strobe, one clock wide
//   wr_en      register write strobe
//   wr_voice   target voice of the write (values >= NUM_VOICES are ignored)
//   wr_addr    0 freq_lo, 1 freq_hi, 2 pw_lo, 3 pw_hi[3:0], 4 control, 5 level
//   wr_data    write data
//   out_valid  one-clock strobe per voice result
//   out_voice  voice index of out_wave
//   out_wave   combined 12-bit unsigned waveform
//   out_msb    accumulator MSB of out_voice after its update
//   sweep_done pulses together with the last voice's out_valid
//   overrun    sticky; set when a tick is lost; cleared only by reset
module sid_voice_bank #(
   parameter int NUM_VOICES = 3,
   parameter int ACC_WIDTH  = 24,
   parameter int VIDX_W     = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ce_1m,
   input  logic              wr_en,
   input  logic [VIDX_W-1:0] wr_voice,
   input  logic [2:0]        wr_addr,
   input  logic [7:0]        wr_data,
   output logic              out_valid,
   output logic [VIDX_W-1:0] out_voice,
   output logic [11:0]       out_wave,
   output logic              out_msb,
   output logic              sweep_done,
   output logic              overrun
);

   localparam int MSB = ACC_WIDTH - 1;
   localparam int NB  = ACC_WIDTH - 5;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t            state;
   logic [VIDX_W-1:0] vcnt;
   logic              pend;
   logic              overrun_r;

   // Bit 0 of control (gate) is not used by the oscillator, so it is not stored.
   logic [7:0]           freq_lo [NUM_VOICES];
   logic [7:0]           freq_hi [NUM_VOICES];
   logic [7:0]           pw_lo   [NUM_VOICES];
   logic [3:0]           pw_hi   [NUM_VOICES];
   logic [7:1]           ctrl    [NUM_VOICES];
   logic [7:0]           level   [NUM_VOICES];
   logic [ACC_WIDTH-1:0] acc     [NUM_VOICES];
   logic [22:0]          lfsr    [NUM_VOICES];
   logic [NUM_VOICES-1:0] snap_prev, snap_cur, msb_vec;

   logic              running, last;
   logic [VIDX_W-1:0] src;

   logic [7:0]           flo_s, fhi_s, pwlo_s, lvl_s;
   logic [3:0]           pwhi_s;
   logic [7:1]           ctl_s;
   logic [ACC_WIDTH-1:0] acc_s, acc_new;
   logic [22:0]          lfsr_s, lfsr_new;
   logic                 sp_src, sc_src;
   logic                 test, sync_hit, nrise, m;
   logic [11:0]          t_top, w_tri, w_saw, w_pulse, w_noise, wave, wave_fin;
   logic                 any_sel;

   logic              vld_p1, msb_p1, done_p1;
   logic [VIDX_W-1:0] voice_p1;
   logic [11:0]       wave_p1;

`ifdef SID_VOICE_BANK_DCA_EN
   function automatic logic [11:0] dca_scale(input logic [11:0] w, input logic [7:0] lvl);
      logic [19:0] prod;
      prod = 20'(w) * 20'(lvl);
      return prod[19:8];
   endfunction
`endif

   assign running = (state == S_RUN);
   assign last    = (vcnt == VIDX_W'(NUM_VOICES - 1));
   assign src     = (vcnt == '0) ? VIDX_W'(NUM_VOICES - 1) : vcnt - VIDX_W'(1);

   // ---- stage p0: select the active voice and compute its update ----
   always_comb begin
      flo_s  = '0;
      fhi_s  = '0;
      pwlo_s = '0;
      pwhi_s = '0;
      ctl_s  = '0;
      lvl_s  = '0;
      acc_s  = '0;
      lfsr_s = '0;
      sp_src = 1'b0;
      sc_src = 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (vcnt == VIDX_W'(i)) begin
            flo_s  = freq_lo[i];
            fhi_s  = freq_hi[i];
            pwlo_s = pw_lo[i];
            pwhi_s = pw_hi[i];
            ctl_s  = ctrl[i];
            lvl_s  = level[i];
            acc_s  = acc[i];
            lfsr_s = lfsr[i];
         end
         if (src == VIDX_W'(i)) begin
            sp_src = snap_prev[i];
            sc_src = snap_cur[i];
         end
      end
   end

   always_comb begin
      test     = ctl_s[3];
      sync_hit = ctl_s[1] & ~sp_src & sc_src;
      if (test || sync_hit)
         acc_new = '0;
      else
         acc_new = acc_s + ACC_WIDTH'({fhi_s, flo_s});
      // Noise clocks on a rising edge of the tap bit between old and new phase.
      nrise    = ~acc_s[NB] & acc_new[NB];
      lfsr_new = nrise ? {lfsr_s[21:0], (lfsr_s[22] | test) ^ lfsr_s[17]} : lfsr_s;

      t_top   = acc_new[MSB -: 12];
      m       = t_top[11] ^ (ctl_s[2] & sc_src);
      w_tri   = {t_top[10:0] ^ {11{m}}, 1'b0};
      w_saw   = t_top;
      w_pulse = (test || (t_top >= {pwhi_s, pwlo_s})) ? 12'hFFF : 12'h000;
      w_noise = {lfsr_new[20], lfsr_new[18], lfsr_new[14], lfsr_new[11],
                 lfsr_new[9],  lfsr_new[5],  lfsr_new[2],  lfsr_new[0], 4'b0000};

      wave    = 12'hFFF;
      any_sel = 1'b0;
      if (ctl_s[4]) begin wave = wave & w_tri;   any_sel = 1'b1; end
      if (ctl_s[5]) begin wave = wave & w_saw;   any_sel = 1'b1; end
      if (ctl_s[6]) begin wave = wave & w_pulse; any_sel = 1'b1; end
      if (ctl_s[7]) begin wave = wave & w_noise; any_sel = 1'b1; end
      if (!any_sel) wave = 12'h000;
   end

`ifdef SID_VOICE_BANK_DCA_EN
   assign wave_fin = dca_scale(wave, lvl_s);
`else
   logic [7:0] level_unused;
   assign level_unused = lvl_s;
   assign wave_fin     = wave;
`endif

   // MSBs for the end-of-sweep snapshot: the voice being processed contributes its new value.
   always_comb begin
      msb_vec = '0;
      for (int i = 0; i < NUM_VOICES; i++)
         msb_vec[i] = (vcnt == VIDX_W'(i)) ? acc_new[MSB] : acc[i][MSB];
   end

   // Register file, per-voice state and snapshots
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            freq_lo[i] <= '0;
            freq_hi[i] <= '0;
            pw_lo[i]   <= '0;
            pw_hi[i]   <= '0;
            ctrl[i]    <= '0;
            level[i]   <= '0;
            acc[i]     <= '0;
            lfsr[i]    <= 23'h7FFFFF;
         end
         snap_prev <= '0;
         snap_cur  <= '0;
      end else begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (wr_en && wr_voice == VIDX_W'(i)) begin
               case (wr_addr)
                  3'd0: freq_lo[i] <= wr_data;
                  3'd1: freq_hi[i] <= wr_data;
                  3'd2: pw_lo[i]   <= wr_data;
                  3'd3: pw_hi[i]   <= wr_data[3:0];
                  3'd4: ctrl[i]    <= wr_data[7:1];
                  3'd5: level[i]   <= wr_data;
                  default: ;
               endcase
            end
            if (running && vcnt == VIDX_W'(i)) begin
               acc[i]  <= acc_new;
               lfsr[i] <= lfsr_new;
            end
         end
         if (running && last) begin
            snap_prev <= snap_cur;
            snap_cur  <= msb_vec;
         end
      end
   end

   // Sweep sequencer with one-deep tick pending slot
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         vcnt      <= '0;
         pend      <= 1'b0;
         overrun_r <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ce_1m) begin
                  state <= S_RUN;
                  vcnt  <= '0;
               end
            end
            S_RUN: begin
               if (last) begin
                  vcnt <= '0;
                  if (pend) begin
                     pend <= 1'b0;
                     if (ce_1m) overrun_r <= 1'b1;
                  end else if (!ce_1m) begin
                     state <= S_IDLE;
                  end
               end else begin
                  vcnt <= vcnt + VIDX_W'(1);
                  if (ce_1m) begin
                     if (pend) overrun_r <= 1'b1;
                     else      pend      <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ---- stage p1: registered outputs ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld_p1   <= 1'b0;
         done_p1  <= 1'b0;
         voice_p1 <= '0;
         wave_p1  <= '0;
         msb_p1   <= 1'b0;
      end else begin
         vld_p1  <= running;
         done_p1 <= running & last;
         if (running) begin
            voice_p1 <= vcnt;
            wave_p1  <= wave_fin;
            msb_p1   <= acc_new[MSB];
         end
      end
   end

   assign out_valid  = vld_p1;
   assign out_voice  = voice_p1;
   assign out_wave   = wave_p1;
   assign out_msb    = msb_p1;
   assign sweep_done = done_p1;
   assign overrun    = overrun_r;

endmodule

// File: tb/tb_sid_voice_bank.sv
// tb_sid_voice_bank
//   Directed bench for sid_voice_bank (NUM_VOICES=3, ACC_WIDTH=24, level feature off).
//   Stimulus pushes hand-computed results into a queue; a monitor pops and
//   compares them whenever out_valid is seen.
module tb_sid_voice_bank;

   localparam int NV = 3;

   logic        clock, reset, ce_1m, wr_en;
   logic [3:0]  wr_voice;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        out_valid, out_msb, sweep_done, overrun;
   logic [3:0]  out_voice;
   logic [11:0] out_wave;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  voice;
      logic [11:0] wave;
      logic        msb;
      logic        done;
   } exp_t;

   exp_t sbq[$];

   sid_voice_bank #(.NUM_VOICES(NV), .ACC_WIDTH(24), .VIDX_W(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .ce_1m      (ce_1m),
      .wr_en      (wr_en),
      .wr_voice   (wr_voice),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .out_valid  (out_valid),
      .out_voice  (out_voice),
      .out_wave   (out_wave),
      .out_msb    (out_msb),
      .sweep_done (sweep_done),
      .overrun    (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Monitor: every out_valid must match the oldest expected entry.
   always @(negedge clock) begin
      if (reset === 1'b1 && out_valid === 1'b1) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid voice=%0d wave=%03h", out_voice, out_wave);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            if ({out_voice, out_wave, out_msb, sweep_done} !== e) begin
               errors++;
               $display("FAIL sb_voice%0d actual v=%0d w=%03h msb=%0b done=%0b required v=%0d w=%03h msb=%0b done=%0b",
                        e.voice, out_voice, out_wave, out_msb, sweep_done,
                        e.voice, e.wave, e.msb, e.done);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic push3(input logic [11:0] w0, input logic m0,
                        input logic [11:0] w1, input logic m1,
                        input logic [11:0] w2, input logic m2);
      sbq.push_back({4'd0, w0, m0, 1'b0});
      sbq.push_back({4'd1, w1, m1, 1'b0});
      sbq.push_back({4'd2, w2, m2, 1'b1});
   endtask

   task automatic wr(input logic [3:0] v, input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_voice = v; wr_addr = a; wr_data = d;
      @(posedge clock); #1;
      wr_en = 1'b0;
   endtask

   task automatic tick();
      ce_1m = 1'b1;
      @(posedge clock); #1;
      ce_1m = 1'b0;
      repeat (NV + 2) @(posedge clock);
      #1;
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk({tag, "_valid"},   out_valid,  0);
      chk({tag, "_wave"},    out_wave,   0);
      chk({tag, "_voice"},   out_voice,  0);
      chk({tag, "_msb"},     out_msb,    0);
      chk({tag, "_done"},    sweep_done, 0);
      chk({tag, "_overrun"}, overrun,    0);
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   initial begin
      logic [23:0] a0, a2;
      logic [11:0] w0;
      reset = 1'b0; ce_1m = 1'b0; wr_en = 1'b0;
      wr_voice = '0; wr_addr = '0; wr_data = '0;
      #1;

      // Basic saw sweep, ignored writes, read-before-write and write-ahead
      do_reset("rst1");
      wr(4'd3, 3'd4, 8'h40);   // no such voice
      wr(4'd1, 3'd6, 8'hFF);   // unused address
      wr(4'd0, 3'd0, 8'h00);
      wr(4'd0, 3'd1, 8'h10);
      wr(4'd0, 3'd4, 8'h20);
      push3(12'h001, 0, 12'h000, 0, 12'h000, 0);
      tick();
      push3(12'h002, 0, 12'h000, 0, 12'hFFF, 0);
      ce_1m = 1'b1;
      @(posedge clock); #1;
      ce_1m = 1'b0;
      wr_en = 1'b1; wr_voice = 4'd0; wr_addr = 3'd4; wr_data = 8'h00;
      @(posedge clock); #1;
      wr_voice = 4'd2; wr_data = 8'h40;
      @(posedge clock); #1;
      wr_en = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      push3(12'h000, 0, 12'h000, 0, 12'hFFF, 0);
      tick();

      // Pulse threshold, test bit, waveform combination
      do_reset("rst2");
      wr(4'd0, 3'd2, 8'h10);
      wr(4'd0, 3'd3, 8'h00);
      wr(4'd0, 3'd0, 8'h00);
      wr(4'd0, 3'd1, 8'h80);
      wr(4'd0, 3'd4, 8'h48);
      push3(12'hFFF, 0, 12'h000, 0, 12'h000, 0); tick();
      push3(12'hFFF, 0, 12'h000, 0, 12'h000, 0); tick();
      wr(4'd0, 3'd4, 8'h40);
      push3(12'h000, 0, 12'h000, 0, 12'h000, 0); tick();   // T=008 < 010
      push3(12'hFFF, 0, 12'h000, 0, 12'h000, 0); tick();   // T=010 == pw
      wr(4'd0, 3'd4, 8'h48);
      push3(12'hFFF, 0, 12'h000, 0, 12'h000, 0); tick();   // acc back to 0
      wr(4'd0, 3'd4, 8'h40);
      push3(12'h000, 0, 12'h000, 0, 12'h000, 0); tick();   // T=008 again
      wr(4'd0, 3'd4, 8'h30);
      push3(12'h000, 0, 12'h000, 0, 12'h000, 0); tick();   // 010 & 020
      push3(12'h010, 0, 12'h000, 0, 12'h000, 0); tick();   // 018 & 030
      wr(4'd0, 3'd4, 8'h00);
      push3(12'h000, 0, 12'h000, 0, 12'h000, 0); tick();   // nothing selected

      // Sync from voice2 MSB rise, then ring modulation
      do_reset("rst3");
      wr(4'd2, 3'd0, 8'hFF);
      wr(4'd2, 3'd1, 8'hFF);
      wr(4'd2, 3'd4, 8'h20);
      wr(4'd0, 3'd0, 8'h00);
      wr(4'd0, 3'd1, 8'h01);
      wr(4'd0, 3'd4, 8'h22);
      for (int k = 1; k <= 134; k++) begin
         a2 = 24'(k * 65535);
         a0 = (k < 130) ? 24'(k * 256) : 24'((k - 130) * 256);
         if (k == 133) begin
            wr(4'd0, 3'd4, 8'h14);
            w0 = 12'hFFE;            // T=000 inverted by ring
         end else if (k == 134) begin
            wr(4'd0, 3'd4, 8'h10);
            w0 = 12'h000;            // same T without ring
         end else begin
            w0 = a0[23:12];
         end
         push3(w0, a0[23], 12'h000, 0, a2[23:12], a2[23]);
         tick();
      end

      // Tick pending and overrun
      do_reset("rst4");
      push3(12'h000, 0, 12'h000, 0, 12'h000, 0);
      push3(12'h000, 0, 12'h000, 0, 12'h000, 0);
      ce_1m = 1'b1;
      repeat (3) begin @(posedge clock); #1; end
      ce_1m = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      chk("overrun_set", overrun, 1);
      push3(12'h000, 0, 12'h000, 0, 12'h000, 0);
      tick();
      chk("overrun_sticky", overrun, 1);

      // Reset in the middle of a sweep
      do_reset("rst5");
      wr(4'd0, 3'd1, 8'h10);
      wr(4'd0, 3'd4, 8'h20);
      ce_1m = 1'b1;
      @(posedge clock); #1;
      ce_1m = 1'b0;
      @(posedge clock); #1;
      chk("mid_valid_before", out_valid, 1);
      chk("mid_wave_before",  out_wave,  12'h001);
      reset = 1'b0;
      #1;
      chk("mid_valid_after", out_valid,  0);
      chk("mid_wave_after",  out_wave,   0);
      chk("mid_done_after",  sweep_done, 0);
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      repeat (6) @(posedge clock);
      #1;

      // Noise clocks only when acc bit 19 rises (tick 16 of freq 0x8000)
      wr(4'd0, 3'd0, 8'h00);
      wr(4'd0, 3'd1, 8'h80);
      wr(4'd0, 3'd4, 8'h80);
      for (int k = 1; k <= 33; k++) begin
         push3((k < 16) ? 12'hFF0 : 12'hFE0, 0, 12'h000, 0, 12'h000, 0);
         tick();
      end

      for (int i = 0; i < 20 && sbq.size() != 0; i++) @(posedge clock);
      #1;
      chk("sb_drain", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
